// File: rtl/led_blink_sequencer_pkg.sv
// Shared encodings for the LED blink sequencer and the blinker it drives.
package led_blink_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        Sel100Hz = 2'b00,
        Sel50Hz  = 2'b01,
        Sel10Hz  = 2'b10,
        Sel1Hz   = 2'b11
    } sel_e;

    function automatic sel_e next_sel(input sel_e cur);
        logic [1:0] nxt;
        nxt = cur + 2'd1;
        return sel_e'(nxt);
    endfunction

endpackage

// File: rtl/led_dwell_timer.sv
// Dwell counter: counts enabled cycles and pulses o_terminal on the last one.
module led_dwell_timer #(
    parameter int unsigned c_DWELL_CNT = 25000,
    parameter int unsigned c_CNT_WIDTH = 32
) (
    input  logic i_clock,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam logic [c_CNT_WIDTH-1:0] TermCnt = c_CNT_WIDTH'(c_DWELL_CNT - 1);

    logic [c_CNT_WIDTH-1:0] dwell_q;

    assign o_terminal = i_enable && (dwell_q == TermCnt);

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            dwell_q <= '0;
        end else if (o_terminal) begin
            dwell_q <= '0;
        end else if (i_enable) begin
            dwell_q <= dwell_q + c_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/led_blink_sequencer.sv
// Steps the blinker through 100/50/10/1 Hz with start/stop, hold, manual step and loop limit.
module led_blink_sequencer
    import led_blink_sequencer_pkg::*;
#(
    parameter int unsigned c_DWELL_CNT = 25000,
    parameter int unsigned c_LOOPS     = 0,
    parameter int unsigned c_CNT_WIDTH = 32
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_stop,
    input  logic i_hold,
    input  logic i_step,
    output logic o_switch_1,
    output logic o_switch_2,
    output logic o_enable,
    output logic o_wrap,
    output logic o_done,
    output logic o_busy
);

    localparam logic [c_CNT_WIDTH-1:0] LoopTerm = c_CNT_WIDTH'(c_LOOPS - 1);

    state_e                 state_q;
    sel_e                   sel_q;
    logic [c_CNT_WIDTH-1:0] loops_q;
    logic                   enable_q;
    logic                   busy_q;
    logic                   wrap_q;
    logic                   done_q;

    logic dwell_clear;
    logic dwell_enable;
    logic dwell_tc;
    logic step_adv;
    logic advance;
    logic last_pass;

    always_comb begin
        // Dwell only runs while active and not frozen; the cycle that enters HOLD does not count.
        dwell_enable = (state_q != StIdle) && !i_stop && !i_hold;
        step_adv     = (state_q == StHold) && !i_stop && i_hold && i_step;
        dwell_clear  = i_reset || (state_q == StIdle) || i_stop || step_adv;
        advance      = dwell_tc || step_adv;
        last_pass    = (c_LOOPS != 0) && (loops_q == LoopTerm);
    end

    led_dwell_timer #(
        .c_DWELL_CNT(c_DWELL_CNT),
        .c_CNT_WIDTH(c_CNT_WIDTH)
    ) u_dwell_timer (
        .i_clock   (i_clock),
        .i_clear   (dwell_clear),
        .i_enable  (dwell_enable),
        .o_terminal(dwell_tc)
    );

    always_ff @(posedge i_clock) begin
        wrap_q <= 1'b0;
        done_q <= 1'b0;
        if (i_reset) begin
            state_q  <= StIdle;
            sel_q    <= Sel100Hz;
            loops_q  <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_start && !i_stop) begin
                        state_q  <= StRun;
                        sel_q    <= Sel100Hz;
                        loops_q  <= '0;
                        enable_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                StRun, StHold: begin
                    if (i_stop) begin
                        state_q  <= StIdle;
                        sel_q    <= Sel100Hz;
                        loops_q  <= '0;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        state_q <= i_hold ? StHold : StRun;
                        if (advance) begin
                            sel_q <= next_sel(sel_q);
                            if (sel_q == Sel1Hz) begin
                                wrap_q <= 1'b1;
                                if (last_pass) begin
                                    done_q   <= 1'b1;
                                    state_q  <= StIdle;
                                    sel_q    <= Sel100Hz;
                                    loops_q  <= '0;
                                    enable_q <= 1'b0;
                                    busy_q   <= 1'b0;
                                end else if (c_LOOPS != 0) begin
                                    loops_q <= loops_q + c_CNT_WIDTH'(1);
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    sel_q    <= Sel100Hz;
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_switch_1 = sel_q[1];
    assign o_switch_2 = sel_q[0];
    assign o_enable   = enable_q;
    assign o_busy     = busy_q;
    assign o_wrap     = wrap_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench: a looping instance (c_LOOPS=2) and a free-running one (c_LOOPS=0), dwell of 4.
module tb_led_blink_sequencer;

    typedef struct packed {
        logic [4:0] in;   // {reset, start, stop, hold, step}
        logic [5:0] exp;  // {sel[1:0], enable, wrap, done, busy}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, stop = 1'b0, hold = 1'b0, step = 1'b0;
    logic a_sw1, a_sw2, a_en, a_wrap, a_done, a_busy;
    logic b_sw1, b_sw2, b_en, b_wrap, b_done, b_busy;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    led_blink_sequencer #(.c_DWELL_CNT(4), .c_LOOPS(2), .c_CNT_WIDTH(32)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_stop(stop), .i_hold(hold),
        .i_step(step), .o_switch_1(a_sw1), .o_switch_2(a_sw2), .o_enable(a_en),
        .o_wrap(a_wrap), .o_done(a_done), .o_busy(a_busy)
    );

    led_blink_sequencer #(.c_DWELL_CNT(4), .c_LOOPS(0), .c_CNT_WIDTH(32)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_stop(stop), .i_hold(hold),
        .i_step(step), .o_switch_1(b_sw1), .o_switch_2(b_sw2), .o_enable(b_en),
        .o_wrap(b_wrap), .o_done(b_done), .o_busy(b_busy)
    );

    wire [5:0] out_a = {a_sw1, a_sw2, a_en, a_wrap, a_done, a_busy};
    wire [5:0] out_b = {b_sw1, b_sw2, b_en, b_wrap, b_done, b_busy};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] in);
        {rst, start, stop, hold, step} = in;
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {sel,en,wrap,done,busy}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] in, input logic [5:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [1:0] s;
        logic       w;

        // Hold/step, stop/start interplay, restart-ignore, reset mid-run, stop+hold.
        add(5'b10000, 6'b000000);
        add(5'b01000, 6'b001001);
        add(5'b00010, 6'b001001);
        add(5'b00011, 6'b011001);
        add(5'b00011, 6'b101001);
        add(5'b00011, 6'b111001);
        add(5'b00011, 6'b001101);
        add(5'b00010, 6'b001001);
        add(5'b00011, 6'b011001);
        add(5'b00011, 6'b101001);
        add(5'b00011, 6'b111001);
        add(5'b00011, 6'b000110);
        add(5'b01100, 6'b000000);
        add(5'b00011, 6'b000000);
        add(5'b01000, 6'b001001);
        add(5'b00000, 6'b001001);
        add(5'b00000, 6'b001001);
        add(5'b01000, 6'b001001);
        add(5'b00000, 6'b011001);
        add(5'b00000, 6'b011001);
        add(5'b00000, 6'b011001);
        add(5'b00000, 6'b011001);
        add(5'b00000, 6'b101001);
        add(5'b10000, 6'b000000);
        add(5'b01000, 6'b001001);
        add(5'b00000, 6'b001001);
        add(5'b00000, 6'b001001);
        add(5'b00000, 6'b001001);
        add(5'b00000, 6'b011001);
        add(5'b00110, 6'b000000);
        add(5'b00000, 6'b000000);

        drive(5'b10000);
        tick();
        check("reset_a", out_a, 6'b000000);
        check("reset_b", out_b, 6'b000000);

        // Uninterrupted run from start: edge n after the start edge.
        drive(5'b01000);
        tick();
        drive(5'b00000);
        for (int n = 0; n <= 100; n++) begin
            if (n > 0) tick();
            s = 2'((n / 4) % 4);
            w = (n > 0) && (n % 16 == 0);
            if (n < 32) check($sformatf("run_a_%0d", n), out_a, {s, 1'b1, w, 1'b0, 1'b1});
            else if (n == 32) check("run_a_done", out_a, 6'b000110);
            else check($sformatf("run_a_idle_%0d", n), out_a, 6'b000000);
            check($sformatf("run_b_%0d", n), out_b, {s, 1'b1, w, 1'b0, 1'b1});
        end

        drive(5'b00100);
        tick();
        check("stop_b", out_b, 6'b000000);

        foreach (vecs[i]) begin
            drive(vecs[i].in);
            tick();
            check($sformatf("vec_%0d", i), out_a, vecs[i].exp);
        end

        // Hold for 10 cycles after two counted cycles on 01, then release.
        drive(5'b10000);
        tick();
        drive(5'b01000);
        tick();
        check("hold_start", out_a, 6'b001001);
        drive(5'b00000);
        for (int i = 0; i < 6; i++) tick();
        check("hold_pre", out_a, 6'b011001);
        drive(5'b00010);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("hold_%0d", i), out_a, 6'b011001);
        end
        drive(5'b00000);
        tick();
        check("hold_rel_1", out_a, 6'b011001);
        tick();
        check("hold_rel_2", out_a, 6'b101001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
